regfile_write_arbiter: RTL

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// Arbitrates register-file writes between pipeline writeback (port A) and a buffered
// long-latency port B, with a starvation drain. Define WARB_BYPASS_EN for same-cycle B bypass.
module regfile_write_arbiter #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     a_valid,
  input  logic [4:0]               a_reg,
  input  logic [31:0]              a_data,
  input  logic                     b_valid,
  output logic                     b_ready,
  input  logic [4:0]               b_reg,
  input  logic [31:0]              b_data,
  output logic                     rf_we,
  output logic [4:0]               rf_waddr,
  output logic [31:0]              rf_wdata,
  output logic                     stall_o,
  input  logic [4:0]               q_reg1,
  input  logic [4:0]               q_reg2,
  output logic                     q_hit1,
  output logic                     q_hit2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {GntNone, GntA, GntFifo, GntBypass} grant_e;

  logic [4:0]       reg_q  [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic             stall_q, stall_d;

  grant_e grant;
  logic   empty, full, a_req, push_hs, enq, pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign b_ready = ~full;
  assign a_req   = a_valid && (a_reg != 5'd0);
  assign push_hs = b_valid && b_ready;

  always_comb begin
    grant = GntNone;
    if (stall_q && !empty) begin
      grant = GntFifo;
    end else if (a_req) begin
      grant = GntA;
    end else if (!empty) begin
      grant = GntFifo;
`ifdef WARB_BYPASS_EN
    end else if (!stall_q && push_hs && (b_reg != 5'd0)) begin
      grant = GntBypass;
`endif
    end
  end

  always_comb begin
    rf_waddr = 5'd0;
    rf_wdata = 32'd0;
    unique case (grant)
      GntA: begin
        rf_waddr = a_reg;
        rf_wdata = a_data;
      end
      GntFifo: begin
        rf_waddr = reg_q[rd_ptr_q];
        rf_wdata = data_q[rd_ptr_q];
      end
      GntBypass: begin
        rf_waddr = b_reg;
        rf_wdata = b_data;
      end
      default: ;
    endcase
    // Async reset also masks the combinational write path.
    rf_we = (grant != GntNone) && !reset;
  end

  assign pop = (grant == GntFifo);
  assign enq = push_hs && (b_reg != 5'd0) && (grant != GntBypass);

  always_comb begin
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + AW'(1);
    end
    if (enq) begin
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + AW'(1);
    end
    count_d = count_q + CW'(enq) - CW'(pop);

    starve_d = '0;
    if (!empty && !pop && (starve_q != SW'(STARVE_LIMIT))) begin
      starve_d = starve_q + SW'(1);
    end
    // A raised stall always forces a pop on the next cycle, so it lasts one cycle.
    stall_d = !stall_q && !empty && !pop && (starve_q == SW'(STARVE_LIMIT - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      reg_q[wr_ptr_q]  <= b_reg;
      data_q[wr_ptr_q] <= b_data;
    end
  end

  always_comb begin
    q_hit1 = 1'b0;
    q_hit2 = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (reg_q[i] == q_reg1)) q_hit1 = 1'b1;
      if (valid_q[i] && (reg_q[i] == q_reg2)) q_hit2 = 1'b1;
    end
    q_hit1 = q_hit1 && (q_reg1 != 5'd0);
    q_hit2 = q_hit2 && (q_reg2 != 5'd0);
  end

  assign stall_o = stall_q;
  assign count   = count_q;

endmodule
